rat_ckpt: RTL and testbench
===========================

// Module: rat_ckpt
// PURPOSE
//  Parametrised rename table (RAT) for the rename stage: maps arch regs to phys regs for RENAME_WIDTH
//  instrs/cycle with intra-group bypass. Holds CP_DEPTH map snapshots in a circular buffer, allocated
//  per branch slot. Adds a committed (retirement) map updated at commit, for full exception flush.
//  Sits between decode and freelist/ROB; checkpoint ids go with branches to the branch unit.
// PARAMETERS
//  RENAME_WIDTH  4   instrs renamed per cycle
//  COMMIT_WIDTH  4   instrs retired per cycle
//  ARF_SIZE      32  arch int regs (AW=$clog2)
//  PRF_SIZE      64  phys int regs (PW=$clog2)
//  CP_DEPTH      4   snapshot slots, power of 2 (CW=$clog2)
// PORTS
//  clock          in   1          rising-edge clock
//  reset          in   1          asynchronous, active-high
//  stall          in   1          hold: no rename/checkpoint state update
//  rd_valid       in   RW         slot i writes rd
//  rs1/rs2/rd     in   RW*AW      arch sources/dest per slot
//  replace_prf    in   RW*PW      new phys reg from freelist per slot
//  ckpt_req       in   RW         slot i is a branch; snapshot map after slot i
//  prs1/prs2      out  RW*PW      renamed sources (combinational)
//  prd            out  RW*PW      = replace_prf when rd_valid && rd!=0, else 0
//  prev_rd        out  RW*PW      prior mapping of rd, to ROB for freeing at commit
//  prev_rd_valid  out  RW         rd_valid && rd!=0
//  ckpt_idx       out  RW*CW      checkpoint id given to slot i (valid where ckpt_req)
//  allocatable    out  1          group can rename this cycle
//  ckpt_release   in   1          oldest branch retired: free head checkpoint
//  recover        in   1          mispredict: restore snapshot recover_idx
//  recover_idx    in   CW
//  flush          in   1          exception: restore committed map, drop all checkpoints
//  commit_valid   in   CW'=COMMIT_WIDTH  slot retires a dest write
//  commit_rd      in   COMMIT_WIDTH*AW
//  commit_prd     in   COMMIT_WIDTH*PW
// BEHAVIOUR
//  Reset: map[i]=committed[i]=i; head=tail=count=0; outputs follow comb logic (prs*=0 with zero inputs).
//  Lookup: prs1[j] = replace_prf[k] of youngest k<j with rd_valid[k]&&rd[k]==rs1[j]&&rd!=0, else map[rs1[j]];
//   same for rs2/prev_rd. x0 always maps to phys 0, never renamed, never bypassed.
//  allocatable = !flush && !recover && (CP_DEPTH-count) >= popcount(ckpt_req).
//  fire = allocatable && !stall: next edge map <= map after all valid slots (youngest wins per rd);
//   for each ckpt_req slot i (in slot order) snap[tail+n] <= map after slots 0..i, ckpt_idx[i]=tail+n;
//   tail += popcount, count += popcount. ckpt_idx combinational, valid only when fire.
//  ckpt_release: head+=1, count-=1; with count==0 it is ignored (bench asserts never driven).
//  Same-cycle alloc+release: count = count + alloc - release; wrap mod CP_DEPTH.
//  recover (must target live id): map<=snap[recover_idx]; tail<=recover_idx+1 (own ckpt kept, younger
//   freed); count recomputed from head after any same-cycle release. Rename ignored that cycle.
//  commit: committed[commit_rd]<=commit_prd per valid slot, youngest wins; rd==0 ignored.
//  flush: map<=committed incl. same-cycle commits; head=tail=count=0. Priority flush > recover > rename.
//  Commit updates apply in every cycle regardless of stall/recover.
// STRUCTURE
//  rat_pkg: arf_idx_t, prf_idx_t, cp_idx_t, map_t (ARF_SIZE x prf_idx_t), rat_reset_map function.
//  Sub-module rat_group_bypass: comb per-slot prefix maps + prs/prev_rd forwarding; reused for snapshots.
//  Storage: map, committed, snap[CP_DEPTH] as flops; head/tail/count regs.
// TESTING
//  Reset, rs1=1..4 no writes -> prs1=1..4, allocatable=1, prev_rd_valid=0.
//  rd={4,6,8,8}, replace_prf={40,41,42,43}, rs1[3]=8 -> prs1[3]=42, prev_rd[3]=42; next cycle x8->43.
//  rd=0 in slot 0 with replace_prf=50 -> prd[0]=0, prev_rd_valid[0]=0, map[0] stays 0.
//  ckpt_req=4'b0010 x4 groups -> ckpt_idx 0,1,2,3; 5th group allocatable=0; ckpt_release -> allocatable=1 next cycle.
//  Rename x5->45 with ckpt at slot1 (id1), later x5->47; recover idx1 -> x5 reads 45, tail=2, count=2.
//  Commit x5->45, then flush with in-flight x5->47 -> x5 reads 45, count=0, allocatable=1; async reset mid-rename -> identity map.

Source files
------------

// File: rtl/rat_pkg.sv
// Shared sizing, types and helpers for the checkpointed rename table.
// The whole slice is configured here so that the port widths and the internal types always agree.
package rat_pkg;

  localparam int unsigned RENAME_WIDTH = 4;
  localparam int unsigned COMMIT_WIDTH = 4;
  localparam int unsigned ARF_SIZE     = 32;
  localparam int unsigned PRF_SIZE     = 64;
  localparam int unsigned CP_DEPTH     = 4;

  localparam int unsigned AW = $clog2(ARF_SIZE);
  localparam int unsigned PW = $clog2(PRF_SIZE);
  localparam int unsigned CW = $clog2(CP_DEPTH);

  typedef logic [AW-1:0] arf_idx_t;
  typedef logic [PW-1:0] prf_idx_t;
  typedef logic [CW-1:0] cp_idx_t;
  typedef logic [CW:0]   cp_cnt_t;
  typedef prf_idx_t [ARF_SIZE-1:0] map_t;

  function automatic map_t rat_reset_map();
    map_t m;
    for (int i = 0; i < ARF_SIZE; i++) begin
      m[i] = prf_idx_t'(i);
    end
    return m;
  endfunction

  // x0 is hardwired to phys 0 whatever the table holds.
  function automatic prf_idx_t rat_lookup(input map_t m, input arf_idx_t a);
    if (a == '0) begin
      return '0;
    end
    return m[a];
  endfunction

endpackage

// File: rtl/rat_group_bypass.sv
// Walks a rename group slot by slot over a base map: per-slot renamed sources, prior dest
// mapping, and the map as it stands after each slot (used for both the next map and snapshots).
module rat_group_bypass
  import rat_pkg::*;
(
  input  map_t                        i_map,
  input  logic [RENAME_WIDTH-1:0]     i_rd_valid,
  input  logic [RENAME_WIDTH*AW-1:0]  i_rd,
  input  logic [RENAME_WIDTH*AW-1:0]  i_rs1,
  input  logic [RENAME_WIDTH*AW-1:0]  i_rs2,
  input  logic [RENAME_WIDTH*PW-1:0]  i_replace_prf,
  output logic [RENAME_WIDTH*PW-1:0]  o_prs1,
  output logic [RENAME_WIDTH*PW-1:0]  o_prs2,
  output logic [RENAME_WIDTH*PW-1:0]  o_prev_rd,
  output map_t [RENAME_WIDTH-1:0]     o_slot_map
);

  map_t w_cur;

  always_comb begin
    w_cur      = i_map;
    o_prs1     = '0;
    o_prs2     = '0;
    o_prev_rd  = '0;
    o_slot_map = '0;
    for (int j = 0; j < RENAME_WIDTH; j++) begin
      // Reading before applying slot j gives exactly the writes of older slots in the group.
      o_prs1[j*PW +: PW]    = rat_lookup(w_cur, i_rs1[j*AW +: AW]);
      o_prs2[j*PW +: PW]    = rat_lookup(w_cur, i_rs2[j*AW +: AW]);
      o_prev_rd[j*PW +: PW] = rat_lookup(w_cur, i_rd[j*AW +: AW]);
      if (i_rd_valid[j] && (i_rd[j*AW +: AW] != '0)) begin
        w_cur[i_rd[j*AW +: AW]] = i_replace_prf[j*PW +: PW];
      end
      o_slot_map[j] = w_cur;
    end
  end

endmodule

// File: rtl/rat_ckpt.sv
// Rename table with a circular buffer of branch snapshots and a committed map for flush.
// Priority of map updates: flush, then recover, then rename; commits always apply.
module rat_ckpt
  import rat_pkg::*;
(
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic                        i_stall,
  input  logic [RENAME_WIDTH-1:0]     i_rd_valid,
  input  logic [RENAME_WIDTH*AW-1:0]  i_rs1,
  input  logic [RENAME_WIDTH*AW-1:0]  i_rs2,
  input  logic [RENAME_WIDTH*AW-1:0]  i_rd,
  input  logic [RENAME_WIDTH*PW-1:0]  i_replace_prf,
  input  logic [RENAME_WIDTH-1:0]     i_ckpt_req,
  output logic [RENAME_WIDTH*PW-1:0]  o_prs1,
  output logic [RENAME_WIDTH*PW-1:0]  o_prs2,
  output logic [RENAME_WIDTH*PW-1:0]  o_prd,
  output logic [RENAME_WIDTH*PW-1:0]  o_prev_rd,
  output logic [RENAME_WIDTH-1:0]     o_prev_rd_valid,
  output logic [RENAME_WIDTH*CW-1:0]  o_ckpt_idx,
  output logic                        o_allocatable,
  input  logic                        i_ckpt_release,
  input  logic                        i_recover,
  input  logic [CW-1:0]               i_recover_idx,
  input  logic                        i_flush,
  input  logic [COMMIT_WIDTH-1:0]     i_commit_valid,
  input  logic [COMMIT_WIDTH*AW-1:0]  i_commit_rd,
  input  logic [COMMIT_WIDTH*PW-1:0]  i_commit_prd
);

  map_t    r_map;
  map_t    r_committed;
  map_t    r_snap [CP_DEPTH];
  cp_idx_t r_head;
  cp_idx_t r_tail;
  cp_cnt_t r_count;

  map_t [RENAME_WIDTH-1:0]    w_slot_map;
  map_t                       w_committed_nxt;
  cp_idx_t [RENAME_WIDTH-1:0] w_ckpt_idx;
  cp_idx_t                    w_off;
  cp_idx_t                    w_rec_head;
  logic [31:0]                w_req_cnt;
  logic                       w_allocatable;
  logic                       w_fire;
  logic                       w_release;

  rat_group_bypass u_bypass (
    .i_map         (r_map),
    .i_rd_valid    (i_rd_valid),
    .i_rd          (i_rd),
    .i_rs1         (i_rs1),
    .i_rs2         (i_rs2),
    .i_replace_prf (i_replace_prf),
    .o_prs1        (o_prs1),
    .o_prs2        (o_prs2),
    .o_prev_rd     (o_prev_rd),
    .o_slot_map    (w_slot_map)
  );

  assign w_req_cnt     = 32'($countones(i_ckpt_req));
  assign w_allocatable = !i_flush && !i_recover &&
                         ((32'(CP_DEPTH) - 32'(r_count)) >= w_req_cnt);
  assign w_fire        = w_allocatable && !i_stall;
  assign w_release     = i_ckpt_release && (r_count != '0);
  assign w_rec_head    = r_head + cp_idx_t'(w_release);
  assign o_allocatable = w_allocatable;
  assign o_ckpt_idx    = w_ckpt_idx;

  always_comb begin
    o_prd           = '0;
    o_prev_rd_valid = '0;
    for (int j = 0; j < RENAME_WIDTH; j++) begin
      o_prev_rd_valid[j] = i_rd_valid[j] && (i_rd[j*AW +: AW] != '0);
      if (o_prev_rd_valid[j]) begin
        o_prd[j*PW +: PW] = i_replace_prf[j*PW +: PW];
      end
    end
  end

  // Branch slots take consecutive ids from the tail in slot order.
  always_comb begin
    w_off      = '0;
    w_ckpt_idx = '0;
    for (int j = 0; j < RENAME_WIDTH; j++) begin
      w_ckpt_idx[j] = r_tail + w_off;
      if (i_ckpt_req[j]) begin
        w_off = w_off + cp_idx_t'(1);
      end
    end
  end

  always_comb begin
    w_committed_nxt = r_committed;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (i_commit_valid[k] && (i_commit_rd[k*AW +: AW] != '0)) begin
        w_committed_nxt[i_commit_rd[k*AW +: AW]] = i_commit_prd[k*PW +: PW];
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_map       <= rat_reset_map();
      r_committed <= rat_reset_map();
      for (int i = 0; i < CP_DEPTH; i++) begin
        r_snap[i] <= rat_reset_map();
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_committed <= w_committed_nxt;
      if (i_flush) begin
        r_map   <= w_committed_nxt;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else if (i_recover) begin
        // Live ids become head..recover_idx inclusive.
        r_map   <= r_snap[i_recover_idx];
        r_tail  <= i_recover_idx + cp_idx_t'(1);
        r_head  <= w_rec_head;
        r_count <= cp_cnt_t'(cp_idx_t'(i_recover_idx - w_rec_head)) + cp_cnt_t'(1);
      end else begin
        if (w_fire) begin
          r_map  <= w_slot_map[RENAME_WIDTH-1];
          r_tail <= r_tail + cp_idx_t'(w_req_cnt);
          for (int j = 0; j < RENAME_WIDTH; j++) begin
            if (i_ckpt_req[j]) begin
              r_snap[w_ckpt_idx[j]] <= w_slot_map[j];
            end
          end
        end
        r_head  <= r_head + cp_idx_t'(w_release);
        r_count <= r_count + (w_fire ? cp_cnt_t'(w_req_cnt) : cp_cnt_t'(0))
                   - cp_cnt_t'(w_release);
      end
    end
  end

endmodule

// File: tb/tb_rat_ckpt.sv
// Directed and random checks of rat_ckpt against a slot-by-slot reference model of the rename
// table, snapshot ring and committed map.
module tb_rat_ckpt;
  import rat_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        stall, ckpt_release, recover, flush;
  logic [3:0]  rd_valid, ckpt_req, commit_valid;
  logic [CW-1:0] recover_idx;
  int t_rs1 [4], t_rs2 [4], t_rd [4], t_rpl [4], t_crd [4], t_cprd [4];

  logic [RENAME_WIDTH*AW-1:0] rs1_f, rs2_f, rd_f;
  logic [RENAME_WIDTH*PW-1:0] rpl_f;
  logic [COMMIT_WIDTH*AW-1:0] crd_f;
  logic [COMMIT_WIDTH*PW-1:0] cprd_f;
  logic [RENAME_WIDTH*PW-1:0] prs1_f, prs2_f, prd_f, prev_rd_f;
  logic [RENAME_WIDTH-1:0]    prev_rd_valid;
  logic [RENAME_WIDTH*CW-1:0] ckpt_idx_f;
  logic                       allocatable;

  always_comb begin
    rs1_f = '0; rs2_f = '0; rd_f = '0; rpl_f = '0; crd_f = '0; cprd_f = '0;
    for (int j = 0; j < 4; j++) begin
      rs1_f[j*AW +: AW]  = AW'(t_rs1[j]);
      rs2_f[j*AW +: AW]  = AW'(t_rs2[j]);
      rd_f[j*AW +: AW]   = AW'(t_rd[j]);
      rpl_f[j*PW +: PW]  = PW'(t_rpl[j]);
      crd_f[j*AW +: AW]  = AW'(t_crd[j]);
      cprd_f[j*PW +: PW] = PW'(t_cprd[j]);
    end
  end

  rat_ckpt dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_stall         (stall),
    .i_rd_valid      (rd_valid),
    .i_rs1           (rs1_f),
    .i_rs2           (rs2_f),
    .i_rd            (rd_f),
    .i_replace_prf   (rpl_f),
    .i_ckpt_req      (ckpt_req),
    .o_prs1          (prs1_f),
    .o_prs2          (prs2_f),
    .o_prd           (prd_f),
    .o_prev_rd       (prev_rd_f),
    .o_prev_rd_valid (prev_rd_valid),
    .o_ckpt_idx      (ckpt_idx_f),
    .o_allocatable   (allocatable),
    .i_ckpt_release  (ckpt_release),
    .i_recover       (recover),
    .i_recover_idx   (recover_idx),
    .i_flush         (flush),
    .i_commit_valid  (commit_valid),
    .i_commit_rd     (crd_f),
    .i_commit_prd    (cprd_f)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state.
  int m_map [32], m_com [32], m_snap [4][32];
  int m_head, m_tail, m_count;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_map[i] = i;
      m_com[i] = i;
    end
    m_head = 0; m_tail = 0; m_count = 0;
  endtask

  // Youngest older slot of the group writing arch reg a wins, else the table.
  function automatic int exp_lookup(input int j, input int a);
    if (a == 0) return 0;
    for (int k = j - 1; k >= 0; k--) begin
      if (rd_valid[k] && t_rd[k] == a) return t_rpl[k];
    end
    return m_map[a];
  endfunction

  function automatic int req_cnt();
    int n = 0;
    for (int j = 0; j < 4; j++) n += int'(ckpt_req[j]);
    return n;
  endfunction

  function automatic bit exp_alloc();
    return !flush && !recover && ((4 - m_count) >= req_cnt());
  endfunction

  task automatic clear_inputs();
    stall = 0; ckpt_release = 0; recover = 0; flush = 0; recover_idx = '0;
    rd_valid = '0; ckpt_req = '0; commit_valid = '0;
    for (int j = 0; j < 4; j++) begin
      t_rs1[j] = 0; t_rs2[j] = 0; t_rd[j] = 0; t_rpl[j] = 0; t_crd[j] = 0; t_cprd[j] = 0;
    end
  endtask

  task automatic check_outputs();
    bit fire;
    int n;
    @(negedge clk);
    fire = exp_alloc() && !stall;
    check("allocatable", 32'(allocatable), 32'(exp_alloc()));
    n = 0;
    for (int j = 0; j < 4; j++) begin
      bit wr;
      wr = rd_valid[j] && (t_rd[j] != 0);
      check($sformatf("prs1[%0d]", j), 32'(prs1_f[j*PW +: PW]), exp_lookup(j, t_rs1[j]));
      check($sformatf("prs2[%0d]", j), 32'(prs2_f[j*PW +: PW]), exp_lookup(j, t_rs2[j]));
      check($sformatf("prev_rd[%0d]", j), 32'(prev_rd_f[j*PW +: PW]), exp_lookup(j, t_rd[j]));
      check($sformatf("prd[%0d]", j), 32'(prd_f[j*PW +: PW]), wr ? t_rpl[j] : 0);
      check($sformatf("prev_rd_valid[%0d]", j), 32'(prev_rd_valid[j]), 32'(wr));
      if (ckpt_req[j]) begin
        if (fire) begin
          check($sformatf("ckpt_idx[%0d]", j), 32'(ckpt_idx_f[j*CW +: CW]), (m_tail + n) % 4);
        end
        n++;
      end
    end
  endtask

  task automatic advance();
    int new_com [32];
    bit fire, rel;
    int n;
    @(posedge clk);
    fire = exp_alloc() && !stall;
    rel  = ckpt_release && (m_count > 0);
    new_com = m_com;
    for (int k = 0; k < 4; k++) begin
      if (commit_valid[k] && t_crd[k] != 0) new_com[t_crd[k]] = t_cprd[k];
    end
    if (flush) begin
      m_map = new_com;
      m_head = 0; m_tail = 0; m_count = 0;
    end else if (recover) begin
      m_map = m_snap[int'(recover_idx)];
      if (rel) m_head = (m_head + 1) % 4;
      m_tail  = (int'(recover_idx) + 1) % 4;
      m_count = ((int'(recover_idx) - m_head + 4) % 4) + 1;
    end else begin
      n = 0;
      if (fire) begin
        for (int i = 0; i < 4; i++) begin
          if (rd_valid[i] && t_rd[i] != 0) m_map[t_rd[i]] = t_rpl[i];
          if (ckpt_req[i]) begin
            m_snap[(m_tail + n) % 4] = m_map;
            n++;
          end
        end
        m_tail = (m_tail + n) % 4;
      end
      m_count = m_count + n - int'(rel);
      if (rel) m_head = (m_head + 1) % 4;
    end
    m_com = new_com;
    #1;
  endtask

  task automatic step();
    check_outputs();
    advance();
  endtask

  task automatic randomize_inputs();
    clear_inputs();
    stall = ($urandom % 8) == 0;
    for (int j = 0; j < 4; j++) begin
      rd_valid[j] = $urandom % 2;
      t_rd[j]   = ($urandom % 2) ? int'($urandom % 8) : int'($urandom % 32);
      t_rs1[j]  = ($urandom % 2) ? int'($urandom % 8) : int'($urandom % 32);
      t_rs2[j]  = int'($urandom % 32);
      t_rpl[j]  = int'($urandom % 64);
      ckpt_req[j] = ($urandom % 5) == 0;
      commit_valid[j] = $urandom % 2;
      t_crd[j]  = int'($urandom % 32);
      t_cprd[j] = int'($urandom % 64);
    end
    if (m_count > 0 && ($urandom % 16) == 0) begin
      recover     = 1;
      recover_idx = CW'((m_head + int'($urandom % m_count)) % 4);
    end else if (m_count > 0) begin
      ckpt_release = ($urandom % 3) == 0;
    end
    flush = ($urandom % 40) == 0;
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    model_reset();
    #12;
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;

    // Identity map after reset.
    for (int j = 0; j < 4; j++) t_rs1[j] = j + 1;
    check_outputs();
    for (int j = 0; j < 4; j++) check($sformatf("reset_prs1[%0d]", j), 32'(prs1_f[j*PW +: PW]), j + 1);
    check("reset_alloc", 32'(allocatable), 1);
    check("reset_prvv", 32'(prev_rd_valid), 0);
    advance();

    // Intra-group bypass, youngest writer of x8 wins.
    clear_inputs();
    rd_valid = 4'b1111;
    t_rd = '{4, 6, 8, 8};
    t_rpl = '{40, 41, 42, 43};
    t_rs1[3] = 8;
    check_outputs();
    check("byp_prs1", 32'(prs1_f[3*PW +: PW]), 42);
    check("byp_prev_rd", 32'(prev_rd_f[3*PW +: PW]), 42);
    advance();
    clear_inputs();
    t_rs1[0] = 8;
    check_outputs();
    check("x8_after", 32'(prs1_f[0 +: PW]), 43);
    advance();

    // x0 is never renamed.
    clear_inputs();
    rd_valid[0] = 1; t_rd[0] = 0; t_rpl[0] = 50;
    check_outputs();
    check("x0_prd", 32'(prd_f[0 +: PW]), 0);
    check("x0_prvv", 32'(prev_rd_valid[0]), 0);
    advance();
    clear_inputs();
    check_outputs();
    check("x0_map", 32'(prs1_f[0 +: PW]), 0);
    advance();

    // Fill the snapshot ring, then free one.
    for (int g = 0; g < 4; g++) begin
      clear_inputs();
      ckpt_req = 4'b0010;
      check_outputs();
      check("fill_idx", 32'(ckpt_idx_f[1*CW +: CW]), g);
      advance();
    end
    clear_inputs();
    ckpt_req = 4'b0010;
    ckpt_release = 1;
    check_outputs();
    check("full_alloc", 32'(allocatable), 0);
    advance();
    ckpt_release = 0;
    check_outputs();
    check("freed_alloc", 32'(allocatable), 1);
    check("wrap_idx", 32'(ckpt_idx_f[1*CW +: CW]), 0);
    advance();
    clear_inputs();
    flush = 1;
    step();

    // Mispredict recovery to checkpoint 1.
    clear_inputs();
    ckpt_req = 4'b0001;
    step();
    clear_inputs();
    rd_valid[0] = 1; t_rd[0] = 5; t_rpl[0] = 45; ckpt_req = 4'b0010;
    check_outputs();
    check("br_idx", 32'(ckpt_idx_f[1*CW +: CW]), 1);
    advance();
    clear_inputs();
    rd_valid[0] = 1; t_rd[0] = 5; t_rpl[0] = 47;
    step();
    clear_inputs();
    recover = 1; recover_idx = CW'(1);
    check_outputs();
    check("rec_alloc", 32'(allocatable), 0);
    advance();
    clear_inputs();
    t_rs1[0] = 5; ckpt_req = 4'b0011;
    check_outputs();
    check("rec_x5", 32'(prs1_f[0 +: PW]), 45);
    check("rec_idx0", 32'(ckpt_idx_f[0 +: CW]), 2);
    check("rec_idx1", 32'(ckpt_idx_f[1*CW +: CW]), 3);
    advance();
    check_outputs();
    check("rec_full", 32'(allocatable), 0);
    advance();

    // Commit then flush with an in-flight rename and a same-cycle commit.
    clear_inputs();
    commit_valid[0] = 1; t_crd[0] = 5; t_cprd[0] = 45;
    step();
    clear_inputs();
    rd_valid[0] = 1; t_rd[0] = 5; t_rpl[0] = 47;
    step();
    clear_inputs();
    flush = 1;
    commit_valid[1] = 1; t_crd[1] = 7; t_cprd[1] = 33;
    step();
    clear_inputs();
    t_rs1[0] = 5; t_rs1[1] = 7; ckpt_req = 4'b1111;
    check_outputs();
    check("fl_x5", 32'(prs1_f[0 +: PW]), 45);
    check("fl_x7", 32'(prs1_f[1*PW +: PW]), 33);
    check("fl_alloc", 32'(allocatable), 1);
    advance();

    // Randomized traffic.
    repeat (400) begin
      randomize_inputs();
      step();
    end

    // Asynchronous reset in the middle of a cycle.
    clear_inputs();
    rd_valid = 4'b1111;
    t_rd = '{1, 2, 3, 4};
    t_rpl = '{60, 61, 62, 63};
    step();
    clear_inputs();
    for (int j = 0; j < 4; j++) t_rs1[j] = j + 1;
    #2;
    rst = 1;
    #1;
    for (int j = 0; j < 4; j++) check($sformatf("arst_prs1[%0d]", j), 32'(prs1_f[j*PW +: PW]), j + 1);
    check("arst_alloc", 32'(allocatable), 1);
    model_reset();
    @(negedge clk);
    rst = 0;
    advance();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
